// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the raster generator: default 800x600 @ 60 Hz
// (40 MHz pixel clock), derived totals/sync starts, and the count width.
package vga_timing_pkg;

  localparam int CNT_W = 11;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 40;
  localparam int H_SYNC_DEF   = 128;
  localparam int H_BP_DEF     = 88;
  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BP_DEF     = 23;

  localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;

  // Half-open window test lo <= val < hi, done at count width.
  function automatic logic in_range(input logic [CNT_W-1:0] val,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus from the timing generator to the rendering pipeline.
// There is no valid/ready handshake: the bus is a free-running stream that
// updates on every enabled pixel clock, and every field is valid in every
// cycle; consumers cannot stall it.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic [CNT_W-1:0] hcount_out;
  logic [CNT_W-1:0] vcount_out;
  logic             hsync_out;
  logic             vsync_out;
  logic             hblnk_out;
  logic             vblnk_out;
  logic             frame_start;
  logic [7:0]       frame_cnt;

  modport master (
    output hcount_out, vcount_out, hsync_out, vsync_out,
    output hblnk_out, vblnk_out, frame_start, frame_cnt
  );

  modport slave (
    input hcount_out, vcount_out, hsync_out, vsync_out,
    input hblnk_out, vblnk_out, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen_mod_counter.sv
// Generic wrap-at-limit counter: counts 0..LIMIT-1 while enabled, exposes the
// value it will take on the next edge and a carry on the wrapping edge.
module mod_counter
  import vga_timing_pkg::*;
#(
  parameter int WIDTH = CNT_W,
  parameter int LIMIT = H_TOTAL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] next_count,
  output logic             carry
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  assign carry = en && (count == LAST);

  // Next value: wrap on carry, increment when enabled, otherwise hold.
  always_comb begin
    next_count = count;
    if (en) begin
      next_count = carry ? '0 : count + WIDTH'(1);
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= next_count;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters plus registered sync,
// blanking and start-of-frame outputs derived from the next counter values so
// they line up with the counts in the same cycle.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  vga_timing_gen_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_BLNK_START = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_BLNK_START = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = SYNC_POL;
  localparam logic SYNC_OFF = ~SYNC_POL;

  // Reject timings that do not fit the 11-bit counters or have empty regions.
  if (H_TOTAL > 2048 || V_TOTAL > 2048 ||
      H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $error("vga_timing_gen: timing parameters out of range");
  end

  logic [CNT_W-1:0] h_cnt, h_next, v_cnt, v_next;
  logic             h_carry, v_carry;
  logic             frame_wrap;

  mod_counter #(.WIDTH(CNT_W), .LIMIT(H_TOTAL)) u_h_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .count      (h_cnt),
    .next_count (h_next),
    .carry      (h_carry)
  );

  mod_counter #(.WIDTH(CNT_W), .LIMIT(V_TOTAL)) u_v_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (en & h_carry),
    .count      (v_cnt),
    .next_count (v_next),
    .carry      (v_carry)
  );

  // Both counters wrapping together means the next cycle is (0,0) of a new frame.
  assign frame_wrap = h_carry & v_carry;

  logic       hblnk_q, vblnk_q, hsync_q, vsync_q, frame_start_q;
  logic [7:0] frame_cnt_q;

  // Status registers follow the next counter values; frame_start is a
  // single-cycle strobe that is dropped whenever counting is paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else if (en) begin
      hblnk_q       <= (h_next >= H_BLNK_START);
      vblnk_q       <= (v_next >= V_BLNK_START);
      hsync_q       <= in_range(h_next, H_SYNC_START, H_SYNC_END) ? SYNC_ON : SYNC_OFF;
      vsync_q       <= in_range(v_next, V_SYNC_START, V_SYNC_END) ? SYNC_ON : SYNC_OFF;
      frame_start_q <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end else begin
      frame_start_q <= 1'b0;
    end
  end

  assign bus.hcount_out  = h_cnt;
  assign bus.vcount_out  = v_cnt;
  assign bus.hsync_out   = hsync_q;
  assign bus.vsync_out   = vsync_q;
  assign bus.hblnk_out   = hblnk_q;
  assign bus.vblnk_out   = vblnk_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule
